// File: rtl/axis_seq_checker.sv
// rtl/axis_seq_checker.sv - stream sink that throttles input and checks beats against a counting lane pattern
module axis_seq_checker #(
  parameter int          DATA_W         = 256,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              enable,
  input  logic              clear,
  input  logic [1:0]        ready_mode,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic              in_tvalid,
  output logic              in_tready,
  output logic [31:0]       cnt_beats,
  output logic [31:0]       cnt_errors,
  output logic              err_seen,
  output logic [31:0]       err_first_idx,
  output logic              timeout
);

  localparam int              LANES    = DATA_W / 32;
  localparam logic [31:0]     LANES_32 = 32'(LANES);
  localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

  logic [15:0]       lfsr_q, lfsr_d;
  logic [1:0]        phase_q, phase_d;
  logic              tready_q, tready_d;
  logic [31:0]       seq_q, seq_d;
  logic [31:0]       beats_q, beats_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d;
  logic [31:0]       cap_seq_q, cap_seq_d;
  logic              cap_vld_q, cap_vld_d;
  logic [31:0]       errors_q, errors_d;
  logic              err_seen_q, err_seen_d;
  logic [31:0]       err_idx_q, err_idx_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              timeout_q, timeout_d;

  logic              hs;
  logic              lfsr_fb;
  logic              rdy_pat;
  logic              mismatch;
  logic [DATA_W-1:0] exp_data;

  assign hs      = in_tvalid & tready_q;
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    rdy_pat = 1'b0;
    case (ready_mode)
      2'd0:    rdy_pat = 1'b1;
      2'd1:    rdy_pat = lfsr_q[0];
      2'd2:    rdy_pat = (phase_q == 2'd3);
      default: rdy_pat = 1'b0;
    endcase
  end

  // Expected beat is rebuilt from the captured index so stage 2 needs no extra state
  always_comb begin
    exp_data = '0;
    for (int k = 0; k < LANES; k++) begin
      exp_data[32*k +: 32] = cap_seq_q * LANES_32 + 32'(k);
    end
  end

  assign mismatch = cap_vld_q && (cap_data_q != exp_data);

  always_comb begin
    lfsr_d     = lfsr_q;
    phase_d    = phase_q;
    tready_d   = tready_q;
    seq_d      = seq_q;
    beats_d    = beats_q;
    cap_data_d = cap_data_q;
    cap_seq_d  = cap_seq_q;
    cap_vld_d  = cap_vld_q;
    errors_d   = errors_q;
    err_seen_d = err_seen_q;
    err_idx_d  = err_idx_q;
    to_cnt_d   = to_cnt_q;
    timeout_d  = timeout_q;

    if (clear) begin
      // Clear beats any same-cycle handshake and drops an in-flight compare
      lfsr_d     = LFSR_SEED;
      phase_d    = 2'd0;
      tready_d   = 1'b0;
      seq_d      = '0;
      beats_d    = '0;
      cap_data_d = '0;
      cap_seq_d  = '0;
      cap_vld_d  = 1'b0;
      errors_d   = '0;
      err_seen_d = 1'b0;
      err_idx_d  = '0;
      to_cnt_d   = '0;
      timeout_d  = 1'b0;
    end else begin
      if (enable) begin
        lfsr_d  = {lfsr_q[14:0], lfsr_fb};
        phase_d = phase_q + 2'd1;
      end
      tready_d  = enable & rdy_pat;

      cap_vld_d = hs;
      if (hs) begin
        cap_data_d = in_tdata;
        cap_seq_d  = seq_q;
        seq_d      = seq_q + 32'd1;
        beats_d    = beats_q + 32'd1;
      end

      if (mismatch) begin
        if (errors_q != 32'hFFFF_FFFF) begin
          errors_d = errors_q + 32'd1;
        end
        if (!err_seen_q) begin
          err_seen_d = 1'b1;
          err_idx_d  = cap_seq_q;
        end
      end

      if (hs) begin
        to_cnt_d = '0;
      end else if (enable && (to_cnt_q != TO_MAX)) begin
        to_cnt_d = to_cnt_q + TO_ONE;
      end
      timeout_d = timeout_q | (to_cnt_d == TO_MAX);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      lfsr_q     <= LFSR_SEED;
      phase_q    <= 2'd0;
      tready_q   <= 1'b0;
      seq_q      <= '0;
      beats_q    <= '0;
      cap_data_q <= '0;
      cap_seq_q  <= '0;
      cap_vld_q  <= 1'b0;
      errors_q   <= '0;
      err_seen_q <= 1'b0;
      err_idx_q  <= '0;
      to_cnt_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      phase_q    <= phase_d;
      tready_q   <= tready_d;
      seq_q      <= seq_d;
      beats_q    <= beats_d;
      cap_data_q <= cap_data_d;
      cap_seq_q  <= cap_seq_d;
      cap_vld_q  <= cap_vld_d;
      errors_q   <= errors_d;
      err_seen_q <= err_seen_d;
      err_idx_q  <= err_idx_d;
      to_cnt_q   <= to_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign in_tready     = tready_q;
  assign cnt_beats     = beats_q;
  assign cnt_errors    = errors_q;
  assign err_seen      = err_seen_q;
  assign err_first_idx = err_idx_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_axis_seq_checker.sv
// tb/tb_axis_seq_checker.sv - directed scenario bench for axis_seq_checker
module tb_axis_seq_checker;

  logic         aclk = 1'b0;
  logic         areset;
  logic         enable;
  logic         clear;
  logic [1:0]   ready_mode;
  logic [255:0] in_tdata;
  logic         in_tvalid;
  logic         in_tready;
  logic [31:0]  cnt_beats;
  logic [31:0]  cnt_errors;
  logic         err_seen;
  logic [31:0]  err_first_idx;
  logic         timeout;

  int n_checks = 0;
  int n_fails  = 0;

  axis_seq_checker #(
    .DATA_W        (256),
    .TIMEOUT_CYCLES(1024),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .enable       (enable),
    .clear        (clear),
    .ready_mode   (ready_mode),
    .in_tdata     (in_tdata),
    .in_tvalid    (in_tvalid),
    .in_tready    (in_tready),
    .cnt_beats    (cnt_beats),
    .cnt_errors   (cnt_errors),
    .err_seen     (err_seen),
    .err_first_idx(err_first_idx),
    .timeout      (timeout)
  );

  always #5 aclk = ~aclk;

  function automatic logic [255:0] mk_beat(input logic [31:0] n);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = n * 32'd8 + 32'(k);
    return r;
  endfunction

  // Called at a negedge; returns at the negedge following the handshake edge.
  task automatic drive_beat(input logic [255:0] d);
    int budget;
    budget    = 0;
    in_tvalid = 1'b1;
    in_tdata  = d;
    while (in_tready !== 1'b1 && budget < 200) begin
      @(negedge aclk);
      budget++;
    end
    n_checks++;
    if (in_tready !== 1'b1) begin
      n_fails++;
      $display("FAIL handshake_wait: in_tready=%b after %0d cycles, required 1", in_tready, budget);
    end
    @(negedge aclk);
  endtask

  task automatic do_clear();
    in_tvalid = 1'b0;
    clear     = 1'b1;
    @(negedge aclk);
    clear     = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1; enable = 1'b0; clear = 1'b0; ready_mode = 2'd0;
    in_tvalid = 1'b0; in_tdata = '0;
    @(negedge aclk);
    @(negedge aclk);
    n_checks++; if (in_tready !== 1'b0) begin n_fails++; $display("FAIL reset_tready: got %b want 0", in_tready); end
    n_checks++; if (cnt_beats !== 32'd0) begin n_fails++; $display("FAIL reset_beats: got %0d want 0", cnt_beats); end
    n_checks++; if (cnt_errors !== 32'd0) begin n_fails++; $display("FAIL reset_errors: got %0d want 0", cnt_errors); end
    n_checks++; if (err_seen !== 1'b0) begin n_fails++; $display("FAIL reset_err_seen: got %b want 0", err_seen); end
    n_checks++; if (err_first_idx !== 32'd0) begin n_fails++; $display("FAIL reset_err_idx: got %0d want 0", err_first_idx); end
    n_checks++; if (timeout !== 1'b0) begin n_fails++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    areset = 1'b0;
  endtask

  task automatic test_mode0_clean();
    enable = 1'b1; ready_mode = 2'd0;
    do_clear();
    @(negedge aclk);
    for (int n = 0; n < 16; n++) begin
      n_checks++;
      if (in_tready !== 1'b1) begin n_fails++; $display("FAIL m0_tready beat %0d: got %b want 1", n, in_tready); end
      drive_beat(mk_beat(32'(n)));
    end
    in_tvalid = 1'b0;
    repeat (3) @(negedge aclk);
    n_checks++; if (cnt_beats !== 32'd16) begin n_fails++; $display("FAIL m0_beats: got %0d want 16", cnt_beats); end
    n_checks++; if (cnt_errors !== 32'd0) begin n_fails++; $display("FAIL m0_errors: got %0d want 0", cnt_errors); end
    n_checks++; if (err_seen !== 1'b0) begin n_fails++; $display("FAIL m0_err_seen: got %b want 0", err_seen); end
    n_checks++; if (timeout !== 1'b0) begin n_fails++; $display("FAIL m0_timeout: got %b want 0", timeout); end
  endtask

  task automatic test_single_error();
    logic [255:0] d;
    enable = 1'b1; ready_mode = 2'd0;
    do_clear();
    for (int n = 0; n < 10; n++) begin
      d = mk_beat(32'(n));
      if (n == 5) d[127:96] = 32'hDEADBEEF;
      drive_beat(d);
      if (n == 5) begin
        n_checks++; if (cnt_errors !== 32'd0) begin n_fails++; $display("FAIL err_latency_early: cnt_errors=%0d one edge after bad handshake, want 0", cnt_errors); end
      end
      if (n == 6) begin
        n_checks++; if (cnt_errors !== 32'd1) begin n_fails++; $display("FAIL err_latency_cnt: got %0d want 1", cnt_errors); end
        n_checks++; if (err_seen !== 1'b1) begin n_fails++; $display("FAIL err_latency_seen: got %b want 1", err_seen); end
        n_checks++; if (err_first_idx !== 32'd5) begin n_fails++; $display("FAIL err_latency_idx: got %0d want 5", err_first_idx); end
      end
    end
    in_tvalid = 1'b0;
    repeat (3) @(negedge aclk);
    n_checks++; if (cnt_errors !== 32'd1) begin n_fails++; $display("FAIL err_final_cnt: got %0d want 1", cnt_errors); end
    n_checks++; if (cnt_beats !== 32'd10) begin n_fails++; $display("FAIL err_final_beats: got %0d want 10", cnt_beats); end
    n_checks++; if (err_first_idx !== 32'd5) begin n_fails++; $display("FAIL err_final_idx: got %0d want 5", err_first_idx); end
  endtask

  task automatic test_dropped_beat();
    logic [31:0] sent [5];
    sent = '{32'd0, 32'd1, 32'd3, 32'd4, 32'd5};
    enable = 1'b1; ready_mode = 2'd0;
    do_clear();
    for (int i = 0; i < 5; i++) drive_beat(mk_beat(sent[i]));
    in_tvalid = 1'b0;
    repeat (3) @(negedge aclk);
    n_checks++; if (cnt_errors !== 32'd3) begin n_fails++; $display("FAIL drop_errors: got %0d want 3", cnt_errors); end
    n_checks++; if (err_first_idx !== 32'd2) begin n_fails++; $display("FAIL drop_idx: got %0d want 2", err_first_idx); end
    n_checks++; if (cnt_beats !== 32'd5) begin n_fails++; $display("FAIL drop_beats: got %0d want 5", cnt_beats); end
  endtask

  task automatic test_mode2_pattern();
    int  acc;
    int  hs_cnt;
    bit  took;
    acc = 0; hs_cnt = 0; took = 1'b0;
    in_tvalid = 1'b0;
    enable = 1'b1; ready_mode = 2'd2; clear = 1'b1;
    @(negedge aclk);
    clear = 1'b0;
    in_tvalid = 1'b1;
    in_tdata = mk_beat(32'd0);
    for (int i = 1; i <= 40; i++) begin
      @(negedge aclk);
      if (took) begin
        acc++;
        in_tdata = mk_beat(32'(acc));
      end
      n_checks++;
      if (in_tready !== ((i % 4) == 0)) begin
        n_fails++;
        $display("FAIL m2_tready cycle %0d: got %b want %b", i, in_tready, ((i % 4) == 0));
      end
      took = (in_tready === 1'b1);
      if (took) hs_cnt++;
    end
    @(negedge aclk);
    in_tvalid = 1'b0;
    repeat (2) @(negedge aclk);
    n_checks++; if (hs_cnt != 10) begin n_fails++; $display("FAIL m2_handshakes: got %0d want 10", hs_cnt); end
    n_checks++; if (cnt_beats !== 32'd10) begin n_fails++; $display("FAIL m2_beats: got %0d want 10", cnt_beats); end
    n_checks++; if (cnt_errors !== 32'd0) begin n_fails++; $display("FAIL m2_errors: got %0d want 0", cnt_errors); end
  endtask

  task automatic test_timeout();
    enable = 1'b1; ready_mode = 2'd0;
    do_clear();
    drive_beat(mk_beat(32'd0));
    drive_beat(mk_beat(32'd7));
    drive_beat(mk_beat(32'd2));
    in_tvalid = 1'b0;
    ready_mode = 2'd3;
    repeat (1023) @(negedge aclk);
    n_checks++; if (timeout !== 1'b0) begin n_fails++; $display("FAIL to_early: timeout=%b after 1023 cycles, want 0", timeout); end
    @(negedge aclk);
    n_checks++; if (timeout !== 1'b1) begin n_fails++; $display("FAIL to_rise: timeout=%b after 1024 cycles, want 1", timeout); end
    repeat (5) @(negedge aclk);
    n_checks++; if (timeout !== 1'b1) begin n_fails++; $display("FAIL to_sticky: got %b want 1", timeout); end
    n_checks++; if (in_tready !== 1'b0) begin n_fails++; $display("FAIL to_mode3_tready: got %b want 0", in_tready); end
    n_checks++; if (cnt_beats !== 32'd3) begin n_fails++; $display("FAIL to_pre_beats: got %0d want 3", cnt_beats); end
    n_checks++; if (cnt_errors !== 32'd1) begin n_fails++; $display("FAIL to_pre_errors: got %0d want 1", cnt_errors); end
    n_checks++; if (err_first_idx !== 32'd1) begin n_fails++; $display("FAIL to_pre_idx: got %0d want 1", err_first_idx); end
    enable = 1'b0;
    do_clear();
    n_checks++; if (timeout !== 1'b0) begin n_fails++; $display("FAIL clr_timeout: got %b want 0", timeout); end
    n_checks++; if (cnt_beats !== 32'd0) begin n_fails++; $display("FAIL clr_beats: got %0d want 0", cnt_beats); end
    n_checks++; if (cnt_errors !== 32'd0) begin n_fails++; $display("FAIL clr_errors: got %0d want 0", cnt_errors); end
    n_checks++; if (err_seen !== 1'b0) begin n_fails++; $display("FAIL clr_err_seen: got %b want 0", err_seen); end
    n_checks++; if (err_first_idx !== 32'd0) begin n_fails++; $display("FAIL clr_err_idx: got %0d want 0", err_first_idx); end
  endtask

  task automatic test_mode1_areset();
    enable = 1'b1; ready_mode = 2'd1;
    do_clear();
    for (int n = 0; n < 1000; n++) begin
      in_tvalid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge aclk);
      drive_beat(mk_beat(32'(n)));
    end
    in_tvalid = 1'b0;
    @(negedge aclk);
    n_checks++; if (cnt_beats !== 32'd1000) begin n_fails++; $display("FAIL m1_beats: got %0d want 1000", cnt_beats); end
    n_checks++; if (cnt_errors !== 32'd0) begin n_fails++; $display("FAIL m1_errors: got %0d want 0", cnt_errors); end
    n_checks++; if (err_seen !== 1'b0) begin n_fails++; $display("FAIL m1_err_seen: got %b want 0", err_seen); end
    in_tvalid = 1'b1;
    in_tdata  = mk_beat(32'd1000);
    #2 areset = 1'b1;
    #1;
    n_checks++; if (in_tready !== 1'b0) begin n_fails++; $display("FAIL ar_tready: got %b want 0", in_tready); end
    n_checks++; if (cnt_beats !== 32'd0) begin n_fails++; $display("FAIL ar_beats: got %0d want 0", cnt_beats); end
    n_checks++; if (cnt_errors !== 32'd0) begin n_fails++; $display("FAIL ar_errors: got %0d want 0", cnt_errors); end
    n_checks++; if (timeout !== 1'b0) begin n_fails++; $display("FAIL ar_timeout: got %b want 0", timeout); end
    @(negedge aclk);
    areset = 1'b0;
    n_checks++; if (cnt_beats !== 32'd0) begin n_fails++; $display("FAIL ar_beat_not_taken: got %0d want 0", cnt_beats); end
    for (int n = 0; n < 5; n++) drive_beat(mk_beat(32'(n)));
    in_tvalid = 1'b0;
    repeat (3) @(negedge aclk);
    n_checks++; if (cnt_beats !== 32'd5) begin n_fails++; $display("FAIL ar_restart_beats: got %0d want 5", cnt_beats); end
    n_checks++; if (cnt_errors !== 32'd0) begin n_fails++; $display("FAIL ar_restart_errors: got %0d want 0", cnt_errors); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mode0_clean();
    test_single_error();
    test_dropped_beat();
    test_mode2_pattern();
    test_timeout();
    test_mode1_areset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/axis_seq_checker.md
Name: axis_seq_checker

Overview:
- Downstream sink for the 256-bit up/down-sizing cascade output stream.
- Accepts beats under a programmable backpressure pattern and checks each beat against a deterministic sequence pattern.
- Counts beats and mismatches, records the first failing beat index, and flags stalls.
- Proves data integrity and ordering through the cascade under throttling; used in simulation and on-board self-test.

Parameters:
- DATA_W, 256: stream width; must be a multiple of 32.
- TIMEOUT_CYCLES, 1024: enabled cycles without a handshake before timeout asserts.
- LFSR_SEED, 16'hACE1: LFSR value after reset/clear; must be non-zero.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  reset, asynchronous, active-high.
- enable  in  1  checker active; when 0, in_tready=0 and timeout counter holds.
- clear  in  1  synchronous; zeroes counters/flags/sequence, reseeds LFSR; wins over a same-cycle handshake.
- ready_mode  in  2  0: always ready; 1: LFSR bit0; 2: one cycle in four; 3: never ready.
- in_tdata  in  DATA_W  stream data.
- in_tvalid  in  1  stream valid.
- in_tready  out  1  stream ready.
- cnt_beats  out  32  accepted beats, wraps.
- cnt_errors  out  32  mismatching beats, saturates at 32'hFFFFFFFF.
- err_seen  out  1  sticky, set on first mismatch.
- err_first_idx  out  32  beat index of first mismatch; valid when err_seen=1.
- timeout  out  1  sticky stall flag.

Behaviour:
- Reset (areset=1, async) and clear: all counters 0, err_seen=0, err_first_idx=0, timeout=0, seq=0, LFSR=LFSR_SEED, phase counter=0, stage-2 valid=0, in_tready=0.
- Handshake = in_tvalid & in_tready at a rising edge. in_tready is registered and may rise without waiting for in_tvalid.
- in_tready for the next cycle = enable & !clear & rdy_pat:
  - mode 0: rdy_pat=1.
  - mode 1: rdy_pat = lfsr[0]. 16-bit Fibonacci LFSR, taps 16,14,13,11, shifts every cycle while enable=1.
  - mode 2: rdy_pat = (phase==3). phase is a 2-bit counter that increments every enabled cycle.
  - mode 3: rdy_pat=0.
- Expected pattern: beat index seq (32-bit, starts at 0). Lane k (bits 32k+31:32k) = seq*(DATA_W/32)+k, mod 2^32.
- Stage 1 (handshake edge): capture in_tdata and seq, increment cnt_beats and seq.
- Stage 2 (next edge): compare the captured beat with the full-width expected value.
  - On mismatch: cnt_errors+1 (saturating).
  - If err_seen=0: set err_seen and load err_first_idx with the captured seq.
- Error-output latency is exactly 2 edges after the handshake; back-to-back beats are fully pipelined at 1 beat/cycle.
- The sequence always advances after a mismatch; there is no resync, so a dropped beat causes continuous errors.
- Timeout:
  - Counter increments each cycle with enable=1 and no handshake.
  - Resets to 0 on a handshake and holds when enable=0.
  - At TIMEOUT_CYCLES, timeout is set (sticky) and the counter saturates.
  - Mode 3 with enable=1 always times out.
- clear with a stage-2 compare in flight: the compare result is discarded.
- areset mid-stream: all state is lost immediately; the upstream beat presented at that time is not accepted.
- cnt_beats wraps 32'hFFFFFFFF to 0 with no flag. seq wraps identically.

Test Plan:
- mode 0, enable=1, 16 beats with lane k = 8n+k, in_tvalid held high → in_tready=1 throughout; cnt_beats=16, cnt_errors=0, err_seen=0, timeout=0.
- mode 0, 10 correct beats but beat 5 lane 3 = 32'hDEADBEEF → 2 edges after that handshake cnt_errors=1, err_seen=1, err_first_idx=5; final cnt_errors=1.
- Drop beat 2 from a 6-beat sequence → cnt_errors=3 (beats 2,3,4 mismatch), err_first_idx=2.
- mode 2, in_tvalid continuously high, 40 cycles → exactly 10 handshakes, each on phase==3; in_tready pattern 0001 repeating.
- mode 3, enable=1, TIMEOUT_CYCLES=1024 → timeout rises 1024 cycles after enable; clear then drops it to 0 and zeroes all counters.
- mode 1, 1000 random-valid beats of the correct sequence, then areset pulse mid-burst → no errors before the reset; all outputs 0 right after areset asserts; cnt_beats restarts from 0.
